// File: rtl/cfg_pkg.sv
// cfg_pkg: shared FSM state type and byte width for the config-chain loader
package cfg_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/ccff_rb_packer.sv
// ccff_rb_packer: packs sampled chain-tail bits MSB-first into readback bytes
module ccff_rb_packer
  import cfg_pkg::*;
(
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              flush,
  output logic [BYTE_W-1:0] data,
  output logic              valid
);
  logic [BYTE_W-2:0] sr;
  logic [2:0]        n;
  logic [BYTE_W-1:0] nxt;
  logic              last;
  assign nxt  = {sr, bit_in};
  assign last = flush || n == 3'd7;
  // collect bits; emit a full byte, or a left-aligned zero-padded partial byte on flush
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      sr    <= '0;
      n     <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= sample_en && last;
      if (sample_en) begin
        sr <= last ? '0 : nxt[BYTE_W-2:0];
        n  <= last ? 3'd0 : n + 3'd1;
        if (last) data <= nxt << (3'd7 - n);
      end
    end
  end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a byte bitstream MSB-first into the config chain and packs readback
module ccff_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 512,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [BYTE_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_shift_en,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  state_t            state;
  logic [BYTE_W-1:0] sh;
  logic [2:0]        bpos;
  logic [CNT_W-1:0]  cnt;
  logic              shifting, last_chain, byte_end, fire, go;
  assign shifting     = state == SHIFT;
  assign last_chain   = cnt == CNT_W'(CHAIN_LEN - 1);
  assign byte_end     = bpos == 3'd7;
  assign bs_ready     = state == LOAD || (shifting && byte_end && !last_chain);
  assign fire         = bs_valid && bs_ready;
  assign go           = start && (state == IDLE || state == DONE);
  assign ccff_head    = sh[BYTE_W-1];
  assign cfg_shift_en = shifting;
  assign busy         = state == LOAD || state == SHIFT;
  assign done         = state == DONE;
  // FSM, byte serializer and saturating shift counter; sh only moves on a shift so the head holds during stalls
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state <= IDLE;
      sh    <= '0;
      bpos  <= '0;
      cnt   <= '0;
    end else begin
      if (go) begin
        state <= LOAD;
        cnt   <= '0;
      end
      if (fire) begin
        sh    <= bs_data;
        bpos  <= '0;
        state <= SHIFT;
      end
      if (shifting) begin
        if (cnt != CNT_W'(CHAIN_LEN)) cnt <= cnt + CNT_W'(1);
        if (last_chain) state <= DONE;
        else if (!byte_end) begin
          sh   <= sh << 1;
          bpos <= bpos + 3'd1;
        end else if (!fire) state <= LOAD;
      end
    end
  end
  ccff_rb_packer u_rb (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .sample_en(shifting),
    .bit_in   (ccff_tail),
    .flush    (shifting && last_chain),
    .data     (rb_data),
    .valid    (rb_valid)
  );
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed bench with a chain model, bit-stream and readback scoreboard
module tb_ccff_chain_loader;
  localparam int N = 20;
  logic       prog_clk = 1'b0, pReset = 1'b0, start = 1'b0, bs_valid = 1'b0;
  logic [7:0] bs_data = '0;
  logic       bs_ready, ccff_head, ccff_tail, cfg_shift_en, rb_valid, busy, done;
  logic [7:0] rb_data;
  int         checks = 0, errors = 0;
  logic [N-1:0] chain = '0, old_chain = '0;
  logic [7:0] exp_bytes [3];
  int         sh_cnt = 0, rb_cnt = 0;
  logic [7:0] rb_q [$];
  logic       prev_done = 0, prev_en = 0, prev_head = 0, prev_rst = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(N)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .bs_data(bs_data),
    .bs_valid(bs_valid), .bs_ready(bs_ready), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .cfg_shift_en(cfg_shift_en), .rb_data(rb_data),
    .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  // external config chain: shifts head in, tail is its MSB
  always @(posedge prog_clk) if (cfg_shift_en) chain <= {chain[N-2:0], ccff_head};
  assign ccff_tail = chain[N-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k-th readback byte: the previous chain contents leave the tail MSB first, zero padded
  function automatic logic [7:0] rb_expect(input logic [N-1:0] old, input int idx);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      int k = 8 * idx + i;
      r[7-i] = (k < N) ? old[N-1-k] : 1'b0;
    end
    return r;
  endfunction

  // k-th chain bit entering the head: bit 7-(k%8) of byte k/8
  function automatic logic head_expect(input int k);
    logic [7:0] b = exp_bytes[k/8];
    return b[7-k%8];
  endfunction

  // per-cycle scoreboard
  always @(negedge prog_clk) begin
    chk("busy_done_excl", busy && done, 0);
    if (rb_valid) begin
      chk("rb_byte", rb_data, rb_expect(old_chain, rb_cnt));
      rb_q.push_back(rb_data);
      rb_cnt++;
    end
    if (cfg_shift_en) begin
      chk("shift_overrun", sh_cnt < N, 1);
      if (sh_cnt < N) chk("head_bit", ccff_head, head_expect(sh_cnt));
      sh_cnt++;
    end else if (!prev_en && prev_rst) chk("head_hold", ccff_head, prev_head);
    if (done && !prev_done) begin
      chk("done_shifts", sh_cnt, N);
      chk("done_after_shift", prev_en, 1);
      chk("done_rb_pulse", rb_valid, 1);
      chk("done_rb_count", rb_cnt, 3);
    end
    if (start && !busy && pReset) begin
      sh_cnt = 0;
      rb_cnt = 0;
      old_chain = chain;
      rb_q.delete();
    end
    if (!pReset) begin
      sh_cnt = 0;
      rb_cnt = 0;
    end
    prev_done = done;
    prev_en   = cfg_shift_en;
    prev_head = ccff_head;
    prev_rst  = pReset;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge prog_clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc = 1'b0;
    bs_data  = b;
    bs_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge prog_clk);
      acc = bs_ready;
      @(posedge prog_clk);
      #1;
    end
    chk("byte_accept", acc, 1);
  endtask

  task automatic wait_done();
    logic ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge prog_clk);
      ok = done;
    end
    chk("done_timeout", ok, 1);
    tick();
  endtask

  task automatic set_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_bytes[0] = a;
    exp_bytes[1] = b;
    exp_bytes[2] = c;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    set_exp(a, b, c);
    do_start();
    send(a);
    send(b);
    send(c);
    bs_valid = 1'b0;
    wait_done();
  endtask

  task automatic chk_reset_outputs();
    @(negedge prog_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_shift_en", cfg_shift_en, 0);
    chk("rst_ready", bs_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_rb_valid", rb_valid, 0);
    chk("rst_rb_data", rb_data, 0);
    @(posedge prog_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic h;
    logic ok;
    tick(3);
    chk_reset_outputs();
    pReset = 1'b1;
    tick();
    // back-to-back load
    load(8'hA5, 8'h3C, 8'hF0);
    chk("t1_chain", chain, 20'hA53CF);
    // preload then readback through an all-zero load
    load(8'h12, 8'h34, 8'h50);
    chk("t2_preload", chain, 20'h12345);
    load(8'h00, 8'h00, 8'h00);
    chk("t2_rb_count", rb_q.size(), 3);
    if (rb_q.size() == 3) begin
      chk("t2_rb0", rb_q[0], 8'h12);
      chk("t2_rb1", rb_q[1], 8'h34);
      chk("t2_rb2", rb_q[2], 8'h50);
    end
    chk("t2_chain", chain, 20'h0);
    // stall after the first byte
    set_exp(8'hA5, 8'h3C, 8'hF0);
    do_start();
    send(8'hA5);
    bs_valid = 1'b0;
    tick(9);
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      if (i == 0) h = ccff_head;
      chk("t3_busy", busy, 1);
      chk("t3_shift_en", cfg_shift_en, 0);
      chk("t3_ready", bs_ready, 1);
      chk("t3_head", ccff_head, h);
      tick();
    end
    send(8'h3C);
    send(8'hF0);
    bs_valid = 1'b0;
    wait_done();
    chk("t3_chain", chain, 20'hA53CF);
    // final byte truncated, extra byte refused in DONE
    set_exp(8'h00, 8'h00, 8'hFF);
    do_start();
    send(8'h00);
    send(8'h00);
    send(8'hFF);
    bs_data = 8'hAA;
    wait_done();
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      chk("t4_ready", bs_ready, 0);
      chk("t4_done", done, 1);
    end
    tick();
    bs_valid = 1'b0;
    chk("t4_chain", chain, 20'h0000F);
    // reset in the middle of a load
    set_exp(8'hA5, 8'h3C, 8'hF0);
    do_start();
    send(8'hA5);
    send(8'h3C);
    bs_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge prog_clk);
      ok = sh_cnt >= 10;
    end
    chk("t5_reach10", ok, 1);
    @(posedge prog_clk);
    #1;
    pReset = 1'b0;
    tick();
    chk_reset_outputs();
    pReset = 1'b1;
    tick();
    load(8'hC3, 8'h5A, 8'h9F);
    chk("t5_chain", chain, 20'hC35A9);
    // start during SHIFT is ignored; start in DONE restarts
    set_exp(8'h5A, 8'hC3, 8'h69);
    do_start();
    fork
      begin
        send(8'h5A);
        send(8'hC3);
        send(8'h69);
        bs_valid = 1'b0;
      end
      begin
        tick(6);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    wait_done();
    chk("t6_chain", chain, 20'h5AC36);
    do_start();
    @(negedge prog_clk);
    chk("t6_done_clr", done, 0);
    chk("t6_busy", busy, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
